// File: rtl/spi_master_arbiter.sv
// -----------------------------------------------------------------------------
// spi_master_arbiter
//
// Purpose:
//   One SPI master datapath (SCLK generator plus MOSI/MISO shifters) shared by
//   NREQ on-chip requesters. A round-robin arbiter picks one request at a time.
//   The winner's TX word and SPI mode (CPOL/CPHA) are latched. The transfer then
//   runs chip-select setup, 2*DATA_W SCLK edges, hold, and release. At the end
//   the received word is returned with a done pulse tagged by requester id.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   req_i        per-requester request level, held until granted
//   req_data_i   per-requester TX word (slice i for requester i), MSB first
//   req_cpol_i   per-requester SCLK idle level
//   req_cpha_i   per-requester phase (0: sample leading, 1: sample trailing)
//   grant_o      one-hot, one-cycle pulse when a request is accepted
//   busy_o       high from the grant cycle to the done cycle inclusive
//   done_o       one-cycle pulse at transfer completion
//   done_id_o    requester id of the last completed transfer
//   rx_data_o    received word of the last completed transfer
//   sclk_o       SPI clock
//   mosi_o       SPI data out
//   miso_i       SPI data in
//   cs_n_o       active-low chip select, one per requester
// -----------------------------------------------------------------------------
module spi_master_arbiter #(
  parameter int NREQ    = 2,
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*DATA_W-1:0]   req_data_i,
  input  logic [NREQ-1:0]          req_cpol_i,
  input  logic [NREQ-1:0]          req_cpha_i,
  output logic [NREQ-1:0]          grant_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [IDW-1:0]           done_id_o,
  output logic [DATA_W-1:0]        rx_data_o,
  output logic                     sclk_o,
  output logic                     mosi_o,
  input  logic                     miso_i,
  output logic [NREQ-1:0]          cs_n_o
);

  localparam int HALF = CLK_DIV / 2;
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int EW   = $clog2(2 * DATA_W + 1);

  localparam logic [HW-1:0]  HALF_LAST = HW'(HALF - 1);
  localparam logic [EW-1:0]  EDGE_LAST = EW'(2 * DATA_W);
  localparam logic [IDW-1:0] ID_LAST   = IDW'(NREQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_e;

  state_e              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [IDW-1:0]      id_q, id_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [HW-1:0]       half_q, half_d;
  logic [EW-1:0]       edge_q, edge_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [IDW-1:0]      done_id_q, done_id_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [NREQ-1:0]     cs_n_q, cs_n_d;

  // Per-requester TX words unpacked for indexed access by the winner id.
  logic [DATA_W-1:0] data_arr [NREQ];
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data_i[gi*DATA_W +: DATA_W];
  end

  // Round-robin search: first asserted request at or above the pointer,
  // wrapping. cand is one bit wider so ptr+offset never overflows before wrap.
  logic            win_found;
  logic [IDW-1:0]  win_idx;
  logic [IDW:0]    cand;
  logic [NREQ-1:0] win_oh;
  logic [IDW-1:0]  ptr_next;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (IDW+1)'(ptr_q) + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!win_found && req_i[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
  end

  assign win_oh   = NREQ'(1) << win_idx;
  assign ptr_next = (win_idx == ID_LAST) ? '0 : win_idx + IDW'(1);

  logic [EW-1:0] edge_k;
  assign edge_k = edge_q + EW'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    half_d    = half_q;
    edge_d    = edge_q;
    grant_d   = '0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_SETUP;
          ptr_d   = ptr_next;
          id_d    = win_idx;
          cpol_d  = req_cpol_i[win_idx];
          cpha_d  = req_cpha_i[win_idx];
          grant_d = win_oh;
          busy_d  = 1'b1;
          cs_n_d  = ~win_oh;
          sclk_d  = req_cpol_i[win_idx];
          half_d  = '0;
          edge_d  = '0;
          rx_d    = '0;
          if (!req_cpha_i[win_idx]) begin
            // Phase 0: MSB must be on the wire before the first (sampling) edge.
            mosi_d = data_arr[win_idx][DATA_W-1];
            tx_d   = data_arr[win_idx] << 1;
          end else begin
            mosi_d = 1'b0;
            tx_d   = data_arr[win_idx];
          end
        end
      end

      S_SETUP, S_XFER: begin
        if (half_q == HALF_LAST) begin
          // One SCLK edge per HALF cycles; edge_k numbers it from 1.
          half_d = '0;
          edge_d = edge_k;
          sclk_d = ~sclk_q;
          if (edge_k[0]) begin
            // Leading edge
            if (cpha_q) begin
              mosi_d = tx_q[DATA_W-1];
              tx_d   = tx_q << 1;
            end else begin
              rx_d = {rx_q[DATA_W-2:0], miso_i};
            end
          end else begin
            // Trailing edge; phase 0 leaves the LSB on the wire after the last one.
            if (cpha_q) begin
              rx_d = {rx_q[DATA_W-2:0], miso_i};
            end else if (edge_k != EDGE_LAST) begin
              mosi_d = tx_q[DATA_W-1];
              tx_d   = tx_q << 1;
            end
          end
          state_d = (edge_k == EDGE_LAST) ? S_HOLD : S_XFER;
        end else begin
          half_d = half_q + HW'(1);
        end
      end

      S_HOLD: begin
        // The done cycle is the last HOLD cycle, so arbitration resumes only
        // after it and cs_n stays high for at least one full cycle between jobs.
        if (done_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (half_q == HALF_LAST) begin
          done_d    = 1'b1;
          cs_n_d    = '1;
          mosi_d    = 1'b0;
          done_id_d = id_q;
          rx_data_d = rx_q;
          half_d    = '0;
        end else begin
          half_d = half_q + HW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      half_q    <= '0;
      edge_q    <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= '1;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      half_q    <= half_d;
      edge_q    <= edge_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
    end
  end

  assign grant_o   = grant_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign done_id_o = done_id_q;
  assign rx_data_o = rx_data_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign cs_n_o    = cs_n_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_master_arbiter
//
// Scoreboard bench for spi_master_arbiter. The driver issues batches of
// requests. For each batch it works out the service order from the round-robin
// rule and pushes one expected record per transfer. A negedge monitor acts as
// the SPI slave of the selected chip. It pops and compares a record on every
// done pulse, and it checks grant/cs_n/busy/sclk/mosi cycle by cycle.
// A second instance with CLK_DIV=2 covers the one-edge-per-cycle case.
// -----------------------------------------------------------------------------
module tb_spi_master_arbiter;
  localparam int NREQ     = 2;
  localparam int DATA_W   = 8;
  localparam int CLK_DIV  = 4;
  localparam int HALF     = CLK_DIV / 2;
  localparam int IDW      = 1;
  localparam int XFER_CYC = (2 * DATA_W + 1) * HALF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Main DUT (CLK_DIV=4)
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*DATA_W-1:0] req_data = '0;
  logic [NREQ-1:0]        req_cpol = '0;
  logic [NREQ-1:0]        req_cpha = '0;
  logic [NREQ-1:0]        grant;
  logic                   busy, done;
  logic [IDW-1:0]         done_id;
  logic [DATA_W-1:0]      rx_data;
  logic                   sclk, mosi, miso;
  logic [NREQ-1:0]        cs_n;
  logic                   loop_m = 1'b1;
  logic                   slv_miso = 1'b0;

  assign miso = loop_m ? mosi : slv_miso;

  spi_master_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_data_i(req_data),
    .req_cpol_i(req_cpol), .req_cpha_i(req_cpha), .grant_o(grant),
    .busy_o(busy), .done_o(done), .done_id_o(done_id), .rx_data_o(rx_data),
    .sclk_o(sclk), .mosi_o(mosi), .miso_i(miso), .cs_n_o(cs_n)
  );

  // Second DUT (CLK_DIV=2), MISO looped back
  logic [NREQ-1:0]        req2 = '0;
  logic [NREQ*DATA_W-1:0] data2 = '0;
  logic [NREQ-1:0]        cpol2 = '0;
  logic [NREQ-1:0]        cpha2 = '0;
  logic [NREQ-1:0]        grant2;
  logic                   busy2, done2;
  logic [IDW-1:0]         done_id2;
  logic [DATA_W-1:0]      rx2;
  logic                   sclk2, mosi2;
  logic [NREQ-1:0]        cs_n2;

  spi_master_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .CLK_DIV(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .req_data_i(data2),
    .req_cpol_i(cpol2), .req_cpha_i(cpha2), .grant_o(grant2),
    .busy_o(busy2), .done_o(done2), .done_id_o(done_id2), .rx_data_o(rx2),
    .sclk_o(sclk2), .mosi_o(mosi2), .miso_i(mosi2), .cs_n_o(cs_n2)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int         id;
    logic [7:0] tx;
    logic [7:0] sw;   // word the slave shifts out
    logic [7:0] rx;   // word the master must receive
    logic       cpol;
    logic       cpha;
  } exp_t;

  exp_t exp_q[$];

  // ---------------------------------------------------------------------------
  // Monitor / slave model
  // ---------------------------------------------------------------------------
  bit              active = 0;
  exp_t            cur;
  int              edge_n = 0;
  int              g_cyc = 0;
  logic            prev_sclk = 1'b0;
  logic [7:0]      mosi_cap = '0;
  logic            last_cpol = 1'b0;
  logic [7:0]      last_rx = '0;
  int              last_id = 0;
  logic [NREQ-1:0] prev_grant = '0;
  logic            prev_done = 1'b0;

  initial forever begin
    logic [NREQ-1:0] exp_cs;
    bit smp;
    @(negedge clk);
    if (!rst_n) begin
      active     = 0;
      last_cpol  = 1'b0;
      last_rx    = '0;
      last_id    = 0;
      prev_grant = '0;
      prev_done  = 1'b0;
      slv_miso   = 1'b0;
    end else begin
      if (prev_grant != '0) check("grant_pulse_width", grant, 0);
      if (prev_done) check("done_pulse_width", done, 0);

      if (grant != '0) begin
        check("grant_while_busy", active, 0);
        if (exp_q.size() == 0) begin
          check("grant_unexpected", grant, 0);
        end else begin
          cur       = exp_q[0];
          check("grant_id", grant, 1 << cur.id);
          active    = 1;
          g_cyc     = cyc;
          edge_n    = 0;
          prev_sclk = sclk;
          mosi_cap  = '0;
          check("sclk_at_grant", sclk, cur.cpol);
          if (!cur.cpha) begin
            slv_miso = cur.sw[7];
            check("mosi_msb_at_grant", mosi, cur.tx[7]);
          end
        end
      end else if (active && sclk !== prev_sclk) begin
        edge_n++;
        check("edge_time", cyc - g_cyc, edge_n * HALF);
        smp = cur.cpha ? (edge_n % 2 == 0) : (edge_n % 2 == 1);
        if (smp) mosi_cap = {mosi_cap[6:0], mosi};
        else if (cur.cpha) slv_miso = cur.sw[7 - (edge_n - 1) / 2];
        else if (edge_n < 2 * DATA_W) slv_miso = cur.sw[7 - edge_n / 2];
        prev_sclk = sclk;
      end

      if (done) begin
        if (!active) begin
          check("done_unexpected", done, 0);
        end else begin
          void'(exp_q.pop_front());
          check("done_id", done_id, cur.id);
          check("rx_data", rx_data, cur.rx);
          check("mosi_word", mosi_cap, cur.tx);
          check("edge_count", edge_n, 2 * DATA_W);
          check("done_time", cyc - g_cyc, XFER_CYC);
          check("sclk_at_done", sclk, cur.cpol);
          last_cpol = cur.cpol;
          last_rx   = cur.rx;
          last_id   = cur.id;
        end
      end else begin
        check("rx_hold", rx_data, last_rx);
        check("id_hold", done_id, last_id);
      end

      check("busy", busy, active);
      exp_cs = '1;
      if (active && !done) exp_cs[cur.id] = 1'b0;
      check("cs_n", cs_n, exp_cs);
      if (!active) begin
        check("sclk_idle", sclk, last_cpol);
        check("mosi_idle", mosi, 0);
      end
      if (done) active = 0;
      prev_grant = grant;
      prev_done  = done;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver and reference model
  // ---------------------------------------------------------------------------
  int         ptr_m = 0;
  int         b_cnt[NREQ];
  logic [7:0] b_tx[NREQ];
  logic [7:0] b_sw[NREQ];
  logic       b_cpol[NREQ];
  logic       b_cpha[NREQ];
  int         rem[NREQ];

  // Service order: repeatedly take the first requester at or after the
  // pointer that still wants a transfer; the pointer moves past the winner.
  task automatic prepare_batch();
    int c[NREQ];
    int left;
    exp_t e;
    left = 0;
    for (int i = 0; i < NREQ; i++) begin
      c[i]   = b_cnt[i];
      rem[i] = b_cnt[i];
      left  += b_cnt[i];
    end
    while (left > 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (ptr_m + k) % NREQ;
        if (c[i] > 0) begin
          e.id   = i;
          e.tx   = b_tx[i];
          e.sw   = b_sw[i];
          e.rx   = loop_m ? b_tx[i] : b_sw[i];
          e.cpol = b_cpol[i];
          e.cpha = b_cpha[i];
          exp_q.push_back(e);
          c[i]--;
          left--;
          ptr_m = (i + 1) % NREQ;
          break;
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*DATA_W +: DATA_W] = b_tx[i];
      req_cpol[i] = b_cpol[i];
      req_cpha[i] = b_cpha[i];
      req[i]      = (b_cnt[i] > 0);
    end
  endtask

  task automatic wait_batch();
    bit ok;
    ok = 0;
    for (int n = 0; n < 1000 && !ok; n++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i] && rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) req[i] = 1'b0;
        end
      end
      if (exp_q.size() == 0 && req == '0 && !busy) ok = 1;
    end
    check("batch_completed", ok, 1);
    if (!ok) begin
      exp_q.delete();
      req = '0;
    end
  endtask

  task automatic set_req(input int i, input int cnt, input logic [7:0] tx,
                         input logic [7:0] sw, input logic cpol, input logic cpha);
    b_cnt[i]  = cnt;
    b_tx[i]   = tx;
    b_sw[i]   = sw;
    b_cpol[i] = cpol;
    b_cpha[i] = cpha;
  endtask

  initial begin
    int  tot;
    int  n;
    int  e2;
    int  g2;
    bit  seen;
    logic p2;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_done_id", done_id, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_cs_n", cs_n, 2'b11);

    // Both requests already high at reset release: served 0 then 1
    loop_m = 1'b1;
    set_req(0, 1, 8'h96, 8'h00, 1'b0, 1'b0);
    set_req(1, 1, 8'h69, 8'h00, 1'b0, 1'b1);
    prepare_batch();
    rst_n = 1'b1;
    wait_batch();

    // Mode 0 loopback, requester 0, 0xA5
    loop_m = 1'b1;
    set_req(0, 1, 8'hA5, 8'h00, 1'b0, 1'b0);
    set_req(1, 0, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk); prepare_batch(); wait_batch();

    // Mode 3, requester 1 sends 0x3C, slave returns 0xC3
    loop_m = 1'b0;
    set_req(0, 0, 8'h00, 8'h00, 1'b0, 1'b0);
    set_req(1, 1, 8'h3C, 8'hC3, 1'b1, 1'b1);
    @(negedge clk); prepare_batch(); wait_batch();

    // Both held for two transfers each: grants alternate
    set_req(0, 2, 8'h12, 8'hE1, 1'b0, 1'b1);
    set_req(1, 2, 8'h34, 8'h7E, 1'b1, 1'b0);
    @(negedge clk); prepare_batch(); wait_batch();

    // Reset in the middle of a transfer (at edge 5)
    loop_m = 1'b0;
    set_req(0, 0, 8'h00, 8'h00, 1'b0, 1'b0);
    set_req(1, 1, 8'hD2, 8'h4B, 1'b1, 1'b0);
    @(negedge clk); prepare_batch();
    n = 0;
    while (n < 200 && !(active && edge_n == 5)) begin
      @(posedge clk); #1;
      n++;
    end
    check("reached_edge5", edge_n, 5);
    rst_n = 1'b0;
    #1;
    check("midrst_cs_n", cs_n, 2'b11);
    check("midrst_sclk", sclk, 0);
    check("midrst_mosi", mosi, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    exp_q.delete();
    req = '0;
    for (int i = 0; i < NREQ; i++) rem[i] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    seen  = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("no_done_after_reset", seen, 0);

    // Requester 1 loopback 0x5A after reset
    loop_m = 1'b1;
    set_req(1, 1, 8'h5A, 8'h00, 1'b0, 1'b0);
    @(negedge clk); prepare_batch(); wait_batch();

    // Randomized batches
    for (int b = 0; b < 30; b++) begin
      tot = 0;
      for (int i = 0; i < NREQ; i++) begin
        set_req(i, int'($urandom_range(2)), 8'($urandom), 8'($urandom),
                1'($urandom), 1'($urandom));
        tot += b_cnt[i];
      end
      if (tot == 0) b_cnt[$urandom_range(NREQ - 1)] = 1;
      loop_m = 1'($urandom);
      @(negedge clk); prepare_batch(); wait_batch();
    end

    // CLK_DIV=2 instance: mode 1, 0xFF loopback on requester 0
    @(negedge clk);
    data2 = 16'h00FF;
    cpol2 = 2'b00;
    cpha2 = 2'b01;
    req2  = 2'b01;
    n = 0;
    while (grant2 == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("div2_grant", grant2, 2'b01);
    g2   = cyc;
    req2 = '0;
    p2   = sclk2;
    e2   = 0;
    n    = 0;
    while (!done2 && n < 40) begin
      @(negedge clk);
      n++;
      if (sclk2 !== p2) begin
        e2++;
        check("div2_edge_time", cyc - g2, e2);
        p2 = sclk2;
      end
    end
    check("div2_done_time", cyc - g2, 17);
    check("div2_edges", e2, 16);
    check("div2_rx_data", rx2, 8'hFF);
    check("div2_done_id", done_id2, 0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
- Shares one SPI master datapath (SCLK generator, MOSI/MISO shifters) between NREQ requesters.
- Round-robin arbiter grants one requester at a time and latches its TX word and SPI mode (CPOL/CPHA).
- Sequences the transfer: chip-select setup, 2*DATA_W SCLK edges with leading/trailing sampling, hold, release.
- Returns received word plus done pulse tagged with requester id. Sits between on-chip peripherals and SPI pins.

Parameters:
NREQ, 2, number of requesters (>=2)
DATA_W, 8, bits per transfer, MSB first
CLK_DIV, 4, clk cycles per SCLK period; even, >=2; HALF = CLK_DIV/2
IDW, $clog2(NREQ), width of requester id

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  transfer request per requester, level; held until grant
req_data  in  NREQ*DATA_W  TX word, slice i for requester i
req_cpol  in  NREQ  SCLK idle level per requester
req_cpha  in  NREQ  0: sample on leading edge; 1: sample on trailing edge
grant  out  NREQ  one-hot, one-cycle pulse when request accepted
busy  out  1  high from grant cycle until done cycle inclusive
done  out  1  one-cycle pulse, transfer complete
done_id  out  IDW  requester id, valid with done, held until next done
rx_data  out  DATA_W  received word, valid with done, held until next done
sclk  out  1  SPI clock
mosi  out  1  SPI data out
miso  in  1  SPI data in
cs_n  out  NREQ  active-low chip select, one per requester

Behaviour:
- Reset values (async, immediate): grant=0, busy=0, done=0, done_id=0, rx_data=0, sclk=0, mosi=0, cs_n=all 1, RR pointer=0, state=IDLE. Applies mid-transfer: no done is issued and the transfer is lost.
- FSM: IDLE -> SETUP -> XFER -> HOLD -> IDLE. All outputs registered.
- IDLE, cycle T, any req high: winner = first asserted index searching from pointer upward, wrapping. Latch data, cpol, cpha, id. Pointer <= winner+1 mod NREQ.
- T+1: grant[winner]=1, busy=1, cs_n[winner]=0, sclk=cpol. If cpha=0, mosi=MSB.
- SETUP lasts HALF cycles.
- XFER: edge k (k=1..2*DATA_W) at cycle T+1+k*HALF; sclk toggles each edge. Odd k = leading, even k = trailing.
- cpha=0:
  - MISO is sampled into rx shift register (MSB first) on leading edges. Sample is the miso value at the clk edge that registers the sclk toggle.
  - MOSI shifts to the next bit on trailing edges, except edge 2*DATA_W.
- cpha=1:
  - MOSI is driven on leading edges; edge 1 drives MSB.
  - MISO is sampled on trailing edges.
- HOLD: HALF cycles, sclk stays at cpol.
- At T+1+(2*DATA_W+1)*HALF: cs_n all 1, done=1, done_id, rx_data updated, mosi=0, busy=1 this cycle, then state=IDLE.
- Earliest next arbitration is the cycle after done; cs_n is high for at least 1 cycle between transfers.
- sclk holds the last transfer's cpol while IDLE. A new grant reloads sclk at the grant cycle.
- req seen during SETUP/XFER/HOLD is ignored until IDLE. A requester still holding req after its done is treated as a new request.
- Simultaneous requests are resolved only by the RR pointer; the loser is served next. No starvation: max wait is NREQ-1 transfers.
- CLK_DIV=2: HALF=1, one edge per clk cycle, same rules apply.

Test Plan:
- Mode 0, DIV=4, W=8, miso looped to mosi, req0 data=0xA5, req asserted at T -> grant=01 at T+1, 16 sclk toggles (first at T+3, last at T+33), done at T+35, done_id=0, rx_data=0xA5, cs_n[0] low T+1..T+34.
- Mode 3 (cpol=1, cpha=1), req1 data=0x3C, miso driven with 0xC3 MSB first, changed on leading edges -> sclk idle 1 before/after, mosi shows 0x3C bits on leading edges, rx_data=0xC3, done_id=1.
- req0 and req1 both high at reset release -> order 0,1. Both kept high -> grants alternate 0,1,0,1 over 4 transfers; each grant pulse exactly 1 cycle.
- rst_n low at edge 5 of a transfer -> same cycle cs_n=11, sclk=0, mosi=0, busy=0, no done. After release, new req1 0x5A completes with rx_data=0x5A (loopback).
- CLK_DIV=2, mode 1, 0xFF loopback -> edges every cycle T+2..T+17, done at T+18, rx_data=0xFF.
